dmi_jtag_ctrl: RTL and testbench

- Sequences Debug Module Interface (DMI) transactions on behalf of the JTAG DTM TAP.
- Owns the DMIACCESS data register: capture, shift and update. Decodes the shifted {addr, data, op} word and issues one request at a time on a valid/ready request channel to the Debug Module.
- Collects the response and keeps the sticky DMI error status that the TAP reports in dtmcs.dmistat.
- Sits between the TAP (tck domain) and the Debug Module front end, in the same clock domain.

---
 rtl/dmi_jtag_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_dmi_jtag_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_jtag_ctrl.sv
// DMIACCESS data register and DMI request/response sequencer for the JTAG DTM.
// Optional response timeout with late-response draining: define DMI_JTAG_CTRL_TIMEOUT_EN.
module dmi_jtag_ctrl #(
  parameter int unsigned AddrWidth     = 7,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                 tck_i,
  input  logic                 rst_i,
  input  logic                 test_logic_reset_i,
  input  logic                 capture_dr_i,
  input  logic                 shift_dr_i,
  input  logic                 update_dr_i,
  input  logic                 dmi_access_i,
  input  logic                 dmi_reset_i,
  input  logic                 tdi_i,
  output logic                 dmi_tdo_o,
  output logic [1:0]           dmi_error_o,
  output logic                 dmi_req_valid_o,
  input  logic                 dmi_req_ready_i,
  output logic [AddrWidth-1:0] dmi_req_addr_o,
  output logic [31:0]          dmi_req_data_o,
  output logic [1:0]           dmi_req_op_o,
  input  logic                 dmi_resp_valid_i,
  output logic                 dmi_resp_ready_o,
  input  logic [31:0]          dmi_resp_data_i,
  input  logic [1:0]           dmi_resp_resp_i
);

  localparam int unsigned DrW = AddrWidth + 34;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    WAIT_READ,
    WAIT_WRITE
  } state_e;

  state_e               state_q, state_d;
  logic [DrW-1:0]       dr_q, dr_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [31:0]          data_q, data_d;
  logic [1:0]           error_q, error_d;

  logic                 capture_en, shift_en, update_en;
  logic                 busy;
  logic [1:0]           capture_err;
  logic                 fail_set;
  logic                 req_valid, resp_ready;
  logic [1:0]           req_op;

  logic [AddrWidth-1:0] upd_addr;
  logic [31:0]          upd_data;
  logic [1:0]           upd_op;

`ifdef DMI_JTAG_CTRL_TIMEOUT_EN
  localparam int unsigned CntW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  assign capture_en = capture_dr_i & dmi_access_i;
  assign shift_en   = shift_dr_i & dmi_access_i;
  assign update_en  = update_dr_i & dmi_access_i;
  assign busy       = (state_q != IDLE);

  assign upd_addr = dr_q[DrW-1:34];
  assign upd_data = dr_q[33:2];
  assign upd_op   = dr_q[1:0];

  // Busy is raised at capture so the op field already reports it in this scan.
  always_comb begin
    capture_err = error_q;
    if (busy && (error_q == 2'd0)) capture_err = 2'd3;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    fail_set   = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'd0;
    resp_ready = 1'b0;
`ifdef DMI_JTAG_CTRL_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
`ifdef DMI_JTAG_CTRL_TIMEOUT_EN
        resp_ready = 1'b1;
`endif
        if (update_en && (error_q == 2'd0)) begin
          if (upd_op == 2'd1) begin
            addr_d  = upd_addr;
            state_d = READ;
          end else if (upd_op == 2'd2) begin
            addr_d  = upd_addr;
            data_d  = upd_data;
            state_d = WRITE;
          end
        end
      end

      READ, WRITE: begin
        req_valid = 1'b1;
        req_op    = (state_q == READ) ? 2'd1 : 2'd2;
        if (dmi_req_ready_i) begin
          state_d = (state_q == READ) ? WAIT_READ : WAIT_WRITE;
`ifdef DMI_JTAG_CTRL_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else if (test_logic_reset_i) begin
          state_d = IDLE;
        end
      end

      WAIT_READ, WAIT_WRITE: begin
        resp_ready = 1'b1;
        if (dmi_resp_valid_i) begin
          if (state_q == WAIT_READ) data_d = dmi_resp_data_i;
          if (dmi_resp_resp_i != 2'd0) fail_set = 1'b1;
          state_d = IDLE;
        end
`ifdef DMI_JTAG_CTRL_TIMEOUT_EN
        else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
          fail_set = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end

      default: state_d = IDLE;
    endcase
  end

  // Later assignments win: response failure beats busy, dmireset beats everything.
  always_comb begin
    error_d = error_q;
    if (capture_en) error_d = capture_err;
    if (update_en && (error_q == 2'd0) && busy) error_d = 2'd3;
    if (test_logic_reset_i) error_d = 2'd0;
    if (fail_set) error_d = 2'd2;
    if (dmi_reset_i) error_d = 2'd0;
  end

  always_comb begin
    dr_d = dr_q;
    if (test_logic_reset_i) begin
      dr_d = '0;
    end else if (capture_en) begin
      dr_d = {addr_q, data_q, capture_err};
    end else if (shift_en) begin
      dr_d = {tdi_i, dr_q[DrW-1:1]};
    end
  end

  always_ff @(posedge tck_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      dr_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      error_q <= 2'd0;
    end else begin
      state_q <= state_d;
      dr_q    <= dr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      error_q <= error_d;
    end
  end

`ifdef DMI_JTAG_CTRL_TIMEOUT_EN
  always_ff @(posedge tck_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

  // Outputs are forced low while reset is asserted.
  assign dmi_tdo_o        = dr_q[0] & ~rst_i;
  assign dmi_error_o      = rst_i ? 2'd0 : error_q;
  assign dmi_req_valid_o  = req_valid & ~rst_i;
  assign dmi_req_op_o     = rst_i ? 2'd0 : req_op;
  assign dmi_req_addr_o   = rst_i ? '0 : addr_q;
  assign dmi_req_data_o   = rst_i ? '0 : data_q;
  assign dmi_resp_ready_o = resp_ready & ~rst_i;

endmodule

// File: tb/tb_dmi_jtag_ctrl.sv
// Self-checking bench for dmi_jtag_ctrl: table-driven transactions plus hand-written corner sequences.
module tb_dmi_jtag_ctrl;

  localparam int AW  = 7;
  localparam int DrW = AW + 34;

  logic          tck = 1'b0;
  logic          rst;
  logic          tlr, capture, shift, update, access, dmireset, tdi;
  logic          tdo;
  logic [1:0]    error;
  logic          req_valid, req_ready;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_data;
  logic [1:0]    req_op;
  logic          resp_valid, resp_ready;
  logic [31:0]   resp_data;
  logic [1:0]    resp_resp;

  int compared   = 0;
  int mismatched = 0;

`ifdef DMI_JTAG_CTRL_TIMEOUT_EN
  localparam logic IdleReady = 1'b1;
`else
  localparam logic IdleReady = 1'b0;
`endif

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    int            ready_delay;
    logic [31:0]   rdata;
    logic [1:0]    resp;
    logic [1:0]    exp_err;
    logic [31:0]   exp_data;
  } vec_t;

  vec_t vecs[4];

  dmi_jtag_ctrl #(.AddrWidth(AW), .TimeoutCycles(8)) dut (
    .tck_i              (tck),
    .rst_i              (rst),
    .test_logic_reset_i (tlr),
    .capture_dr_i       (capture),
    .shift_dr_i         (shift),
    .update_dr_i        (update),
    .dmi_access_i       (access),
    .dmi_reset_i        (dmireset),
    .tdi_i              (tdi),
    .dmi_tdo_o          (tdo),
    .dmi_error_o        (error),
    .dmi_req_valid_o    (req_valid),
    .dmi_req_ready_i    (req_ready),
    .dmi_req_addr_o     (req_addr),
    .dmi_req_data_o     (req_data),
    .dmi_req_op_o       (req_op),
    .dmi_resp_valid_i   (resp_valid),
    .dmi_resp_ready_o   (resp_ready),
    .dmi_resp_data_i    (resp_data),
    .dmi_resp_resp_i    (resp_resp)
  );

  always #5 tck = ~tck;

  task automatic tick();
    @(posedge tck);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic shiftDr(input logic [DrW-1:0] din, output logic [DrW-1:0] dout, input bit do_capture);
    if (do_capture) begin
      capture = 1'b1;
      tick();
      capture = 1'b0;
    end
    for (int i = 0; i < DrW; i++) begin
      shift   = 1'b1;
      tdi     = din[i];
      dout[i] = tdo;
      tick();
    end
    shift = 1'b0;
    tdi   = 1'b0;
  endtask

  task automatic updateDr();
    update = 1'b1;
    tick();
    update = 1'b0;
  endtask

  task automatic pulseDmiReset();
    dmireset = 1'b1;
    tick();
    dmireset = 1'b0;
  endtask

  // Issue a write and let the DM accept it, leaving the controller in WaitWrite.
  task automatic startWrite(input logic [AW-1:0] a, input logic [31:0] d);
    logic [DrW-1:0] dout;
    shiftDr({a, d, 2'd2}, dout, 1'b1);
    updateDr();
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [DrW-1:0] dout;
    shiftDr({v.addr, v.wdata, v.op}, dout, 1'b1);
    updateDr();
    for (int k = 0; k <= v.ready_delay; k++) begin
      checkOutput("req_valid", 64'(req_valid), 64'd1);
      checkOutput("req_op", 64'(req_op), 64'(v.op));
      checkOutput("req_addr", 64'(req_addr), 64'(v.addr));
      if (v.op == 2'd2) checkOutput("req_data", 64'(req_data), 64'(v.wdata));
      if (k == v.ready_delay) req_ready = 1'b1;
      tick();
    end
    req_ready = 1'b0;
    checkOutput("valid_after_accept", 64'(req_valid), 64'd0);
    checkOutput("resp_ready_wait", 64'(resp_ready), 64'd1);
    resp_valid = 1'b1;
    resp_data  = v.rdata;
    resp_resp  = v.resp;
    tick();
    resp_valid = 1'b0;
    resp_resp  = 2'd0;
    checkOutput("resp_ready_idle", 64'(resp_ready), 64'(IdleReady));
    checkOutput("error_after_resp", 64'(error), 64'(v.exp_err));
    shiftDr('0, dout, 1'b1);
    checkOutput("captured_dr", 64'(dout), 64'({v.addr, v.exp_data, v.exp_err}));
    if (v.exp_err != 2'd0) begin
      shiftDr({7'h11, 32'h0, 2'd1}, dout, 1'b0);
      updateDr();
      checkOutput("no_req_while_error", 64'(req_valid), 64'd0);
      tick();
      checkOutput("no_req_while_error2", 64'(req_valid), 64'd0);
      pulseDmiReset();
      checkOutput("error_cleared", 64'(error), 64'd0);
    end
  endtask

  initial begin
    logic [DrW-1:0] dout;
    vec_t rd;

    vecs[0] = '{op: 2'd1, addr: 7'h10, wdata: 32'h0, ready_delay: 2, rdata: 32'hDEADBEEF,
                resp: 2'd0, exp_err: 2'd0, exp_data: 32'hDEADBEEF};
    vecs[1] = '{op: 2'd2, addr: 7'h04, wdata: 32'h12345678, ready_delay: 0, rdata: 32'hFFFF0000,
                resp: 2'd0, exp_err: 2'd0, exp_data: 32'h12345678};
    vecs[2] = '{op: 2'd1, addr: 7'h7F, wdata: 32'h0, ready_delay: 1, rdata: 32'hA5A50001,
                resp: 2'd2, exp_err: 2'd2, exp_data: 32'hA5A50001};
    vecs[3] = '{op: 2'd2, addr: 7'h00, wdata: 32'hFFFFFFFF, ready_delay: 3, rdata: 32'h0,
                resp: 2'd1, exp_err: 2'd2, exp_data: 32'hFFFFFFFF};
    rd      = '{op: 2'd1, addr: 7'h02, wdata: 32'h0, ready_delay: 1, rdata: 32'hCAFEF00D,
                resp: 2'd0, exp_err: 2'd0, exp_data: 32'hCAFEF00D};

    rst = 1'b1; tlr = 1'b0; capture = 1'b0; shift = 1'b0; update = 1'b0;
    access = 1'b1; dmireset = 1'b0; tdi = 1'b0; req_ready = 1'b0;
    resp_valid = 1'b0; resp_data = '0; resp_resp = '0;

    tick();
    checkOutput("reset_valid", 64'(req_valid), 64'd0);
    checkOutput("reset_error", 64'(error), 64'd0);
    checkOutput("reset_resp_ready", 64'(resp_ready), 64'd0);
    rst = 1'b0;
    tick();
    checkOutput("post_reset_valid", 64'(req_valid), 64'd0);
    checkOutput("post_reset_tdo", 64'(tdo), 64'd0);
    checkOutput("post_reset_op", 64'(req_op), 64'd0);

    for (int i = 0; i < 4; i++) begin
      $display("[TB] vector %0d", i);
      applyStimulus(vecs[i]);
    end

    $display("[TB] busy sequence");
    startWrite(7'h01, 32'h00000055);
    checkOutput("busy_wait_ready", 64'(resp_ready), 64'd1);
    shiftDr({7'h02, 32'h0, 2'd1}, dout, 1'b1);
    checkOutput("busy_capture", 64'(dout), 64'({7'h01, 32'h00000055, 2'd3}));
    checkOutput("busy_error", 64'(error), 64'd3);
    updateDr();
    checkOutput("busy_no_req", 64'(req_valid), 64'd0);
    checkOutput("busy_still_wait", 64'(resp_ready), 64'd1);
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    checkOutput("busy_sticky", 64'(error), 64'd3);
    pulseDmiReset();
    checkOutput("busy_cleared", 64'(error), 64'd0);
    applyStimulus(rd);

    $display("[TB] update colliding with failed response");
    startWrite(7'h03, 32'h0000AAAA);
    shiftDr({7'h03, 32'h0, 2'd1}, dout, 1'b0);
    update = 1'b1; resp_valid = 1'b1; resp_resp = 2'd2;
    tick();
    update = 1'b0; resp_valid = 1'b0; resp_resp = 2'd0;
    checkOutput("collide_error", 64'(error), 64'd2);
    checkOutput("collide_no_req", 64'(req_valid), 64'd0);
    pulseDmiReset();
    checkOutput("collide_cleared", 64'(error), 64'd0);

    $display("[TB] dmireset with failed response");
    startWrite(7'h05, 32'h00000001);
    resp_valid = 1'b1; resp_resp = 2'd3; dmireset = 1'b1;
    tick();
    resp_valid = 1'b0; resp_resp = 2'd0; dmireset = 1'b0;
    checkOutput("dmireset_priority", 64'(error), 64'd0);

    $display("[TB] reset during read");
    shiftDr({7'h05, 32'h0, 2'd1}, dout, 1'b1);
    updateDr();
    checkOutput("pre_reset_valid", 64'(req_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("reset_mid_valid", 64'(req_valid), 64'd0);
    checkOutput("reset_mid_error", 64'(error), 64'd0);
    applyStimulus(rd);

    $display("[TB] test-logic-reset during read and wait");
    shiftDr({7'h06, 32'h0, 2'd1}, dout, 1'b1);
    updateDr();
    tlr = 1'b1;
    tick();
    tlr = 1'b0;
    checkOutput("tlr_read_valid", 64'(req_valid), 64'd0);
    startWrite(7'h07, 32'h00000002);
    tlr = 1'b1;
    tick();
    tlr = 1'b0;
    checkOutput("tlr_wait_holds", 64'(resp_ready), 64'd1);
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    checkOutput("tlr_wait_done", 64'(resp_ready), 64'(IdleReady));

`ifdef DMI_JTAG_CTRL_TIMEOUT_EN
    $display("[TB] timeout");
    startWrite(7'h08, 32'h00000077);
    repeat (7) tick();
    checkOutput("timeout_not_yet", 64'(error), 64'd0);
    tick();
    checkOutput("timeout_error", 64'(error), 64'd2);
    checkOutput("timeout_valid", 64'(req_valid), 64'd0);
    resp_valid = 1'b1; resp_data = 32'h11111111; resp_resp = 2'd0;
    tick();
    resp_valid = 1'b0;
    checkOutput("late_resp_error", 64'(error), 64'd2);
    pulseDmiReset();
    shiftDr('0, dout, 1'b1);
    checkOutput("late_resp_data", 64'(dout), 64'({7'h08, 32'h00000077, 2'd0}));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
